// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one line-wide main-memory port between the I-cache miss path and the
// D-cache miss/write-back path. One request is accepted at a time and each
// grant runs exactly one memory transaction. Simultaneous requests are
// resolved round-robin; after reset the D side wins the first tie.
//
// Ports
//   Clk, Reset_N         : clock (rising edge), asynchronous active-low reset
//   i_req / i_addr       : I-side line-fill request, held until i_ack
//   i_ack / i_rdata      : one-cycle completion pulse and returned line
//   d_req / d_we         : D-side request, 1 = line write-back, 0 = line fill
//   d_addr / d_wdata     : D-side address and write-back line
//   d_ack / d_rdata      : one-cycle completion pulse and returned line
//   mem_readM/mem_writeM : memory strobes, high for the whole transaction
//   mem_address          : line-aligned address (0 while no transaction)
//   mem_wdata            : write line (0 while no transaction)
//   mem_rdata/mem_ready  : memory read line and single-cycle completion
//   num_mem_access       : wrapping count of completed memory transactions
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_SIZE  = 16,
  // Must be a power of 2: the line offset is cleared with a bit mask.
  parameter int LINE_WORDS = 4,
  parameter int LINE_BITS  = WORD_SIZE * LINE_WORDS
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [LINE_BITS-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_ack,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] num_mem_access
);

  // Clears the word-within-line offset bits of an address.
  localparam logic [WORD_SIZE-1:0] LINE_MASK = ~WORD_SIZE'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_d_q, last_d_d;   // 1: D was served last
  logic [WORD_SIZE-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_BITS-1:0]   d_rdata_q, d_rdata_d;
  logic [WORD_SIZE-1:0]   count_q, count_d;

  logic                   grant_i, grant_d;
  logic                   busy;

  // Round-robin tie break: on a tie D wins unless D was the last one served.
  always_comb begin
    grant_d = d_req && (!i_req || !last_d_q);
    grant_i = i_req && !grant_d;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values that existed before the edge, independent of block ordering.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational output gets a default first, so no branch can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
        end else if (grant_i) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I:  if (mem_ready) state_d = RESP_I;
      BUSY_D:  if (mem_ready) state_d = RESP_D;
      RESP_I,
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch on grant, line capture and count on completion
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    count_d   = count_q;

    if (state_q == IDLE) begin
      if (grant_d) begin
        last_d_d = 1'b1;
        addr_d   = d_addr & LINE_MASK;
        we_d     = d_we;
        wdata_d  = d_wdata;
      end else if (grant_i) begin
        // I-side transactions are always reads.
        last_d_d = 1'b0;
        addr_d   = i_addr & LINE_MASK;
        we_d     = 1'b0;
        wdata_d  = '0;
      end
    end

    if (state_q == BUSY_I && mem_ready) begin
      i_rdata_d = mem_rdata;
      count_d   = count_q + 1'b1;
    end

    if (state_q == BUSY_D && mem_ready) begin
      // A write-back returns no line; the last fill stays visible.
      if (!we_q) begin
        d_rdata_d = mem_rdata;
      end
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      last_d_q  <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      count_q   <= '0;
    end else begin
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: strobes come only from state and latched values, never
  // from the requester inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy           = (state_q == BUSY_I) || (state_q == BUSY_D);
    mem_readM      = busy && !we_q;
    mem_writeM     = busy && we_q;
    mem_address    = busy ? addr_q  : '0;
    mem_wdata      = busy ? wdata_q : '0;
    i_ack          = (state_q == RESP_I);
    d_ack          = (state_q == RESP_D);
    i_rdata        = i_rdata_q;
    d_rdata        = d_rdata_q;
    num_mem_access = count_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A directed prologue walks through the
// basic read, tie ordering, write-back, spurious completion, mid-transaction
// reset and counter wrap; a randomized phase follows. A memory responder
// serves strobes from a golden line store with random latency. A monitor
// keeps a transaction-level model of the arbiter, pushes the expected
// response on each predicted grant and pops/compares it whenever an ack is
// presented.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int LB = 64;

  logic          Clk = 1'b0;
  logic          Reset_N;
  logic          i_req, d_req, d_we;
  logic [W-1:0]  i_addr, d_addr;
  logic [LB-1:0] d_wdata;
  logic          i_ack, d_ack;
  logic [LB-1:0] i_rdata, d_rdata;
  logic          mem_readM, mem_writeM;
  logic [W-1:0]  mem_address;
  logic [LB-1:0] mem_wdata;
  logic [LB-1:0] mem_rdata;
  logic          mem_ready;
  logic [W-1:0]  num_mem_access;

  mem_arbiter dut (
    .Clk            (Clk),
    .Reset_N        (Reset_N),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_ack          (i_ack),
    .i_rdata        (i_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ack          (d_ack),
    .d_rdata        (d_rdata),
    .mem_readM      (mem_readM),
    .mem_writeM     (mem_writeM),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .num_mem_access (num_mem_access)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Golden memory: unwritten lines return a pattern derived from the address.
  // ---------------------------------------------------------------------------
  logic [LB-1:0] golden [logic [W-1:0]];

  function automatic logic [LB-1:0] line_init(input logic [W-1:0] a);
    return {a, ~a, a ^ 16'hA5A5, a + 16'h1234};
  endfunction

  function automatic logic [LB-1:0] read_line(input logic [W-1:0] a);
    if (golden.exists(a)) return golden[a];
    return line_init(a);
  endfunction

  // Responder controls, written only by the main process.
  int fixed_lat = -1;   // >=0: fixed extra cycles before mem_ready
  int spur_cnt  = 0;    // bumped to request one spurious mem_ready
  int force_cnt = 0;    // bumped when the counter is forced to 0xFFFF

  // ---------------------------------------------------------------------------
  // Memory responder (drives on the falling edge)
  // ---------------------------------------------------------------------------
  initial begin
    bit active;
    int cnt;
    int spur_done;
    active    = 1'b0;
    cnt       = 0;
    spur_done = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    golden[16'h0010] = 64'h1111_2222_3333_4444;
    forever begin
      @(negedge Clk);
      mem_ready = 1'b0;
      if (!Reset_N) begin
        active = 1'b0;
      end else if (mem_readM || mem_writeM) begin
        if (!active) begin
          active = 1'b1;
          cnt    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          if (mem_writeM) begin
            golden[mem_address] = mem_wdata;
            mem_rdata = {$urandom, $urandom};
          end else begin
            mem_rdata = read_line(mem_address);
          end
          mem_ready = 1'b1;
          active    = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        active = 1'b0;
        if (spur_cnt != spur_done || $urandom_range(0, 7) == 0) begin
          spur_done = spur_cnt;
          mem_ready = 1'b1;
          mem_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor + scoreboard (samples 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  typedef enum {M_FREE, M_BUSY, M_RESP} mphase_e;
  typedef struct {
    bit            side_d;
    logic [LB-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  initial begin
    mphase_e       ph;
    bit            cur_d, cur_we, last_d;
    logic [W-1:0]  cur_addr, exp_count;
    logic [LB-1:0] cur_wdata, cur_exp, exp_i, exp_d;
    int            force_seen;
    exp_t          e;
    ph = M_FREE; cur_d = 0; cur_we = 0; last_d = 0;
    cur_addr = '0; exp_count = '0; cur_wdata = '0; cur_exp = '0;
    exp_i = '0; exp_d = '0; force_seen = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset_N) begin
        ph = M_FREE; last_d = 1'b0; exp_count = '0; exp_i = '0; exp_d = '0;
        sb_q.delete();
        check("reset_outs", 128'({i_ack, d_ack, mem_readM, mem_writeM, mem_address,
                                  num_mem_access, mem_wdata}), 128'(0));
        check("reset_rdata", 128'({i_rdata, d_rdata}), 128'(0));
      end else begin
        if (force_seen != force_cnt) begin
          force_seen = force_cnt;
          exp_count  = 16'hFFFF;
        end
        case (ph)
          M_FREE: begin
            if (i_req || d_req) begin
              // On a tie the side that was not served last goes first.
              if (i_req && d_req) cur_d = !last_d;
              else                cur_d = d_req;
              last_d    = cur_d;
              cur_addr  = (cur_d ? d_addr : i_addr) & 16'hFFFC;
              cur_we    = cur_d && d_we;
              cur_wdata = d_wdata;
              cur_exp   = cur_we ? exp_d : read_line(cur_addr);
              sb_q.push_back('{cur_d, cur_exp});
              ph = M_BUSY;
            end
          end
          M_BUSY: begin
            if (mem_ready) begin
              ph = M_RESP;
              exp_count++;
              if (cur_d) exp_d = cur_exp;
              else       exp_i = cur_exp;
            end
          end
          default: ph = M_FREE;
        endcase

        case (ph)
          M_BUSY: begin
            check("busy_port", 128'({i_ack, d_ack, mem_readM, mem_writeM, mem_address}),
                  128'({2'b00, !cur_we, cur_we, cur_addr}));
            if (cur_we) check("busy_wdata", 128'(mem_wdata), 128'(cur_wdata));
          end
          M_RESP: begin
            check("resp_port", 128'({i_ack, d_ack, mem_readM, mem_writeM, mem_address}),
                  128'({!cur_d, cur_d, 2'b00, 16'h0000}));
          end
          default: begin
            check("idle_port", 128'({i_ack, d_ack, mem_readM, mem_writeM, mem_address,
                                     mem_wdata}), 128'(0));
          end
        endcase

        if (i_ack || d_ack) begin
          if (sb_q.size() == 0) begin
            check("ack_expected", 128'({i_ack, d_ack}), 128'(0));
          end else begin
            e = sb_q.pop_front();
            check("ack_side", 128'({i_ack, d_ack}), 128'(e.side_d ? 2'b01 : 2'b10));
            check("ack_rdata", 128'(e.side_d ? d_rdata : i_rdata), 128'(e.rdata));
          end
        end
        check("count", 128'(num_mem_access), 128'(exp_count));
        check("rdata_hold", 128'({i_rdata, d_rdata}), 128'({exp_i, exp_d}));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_any(output logic [1:0] acks);
    acks = 2'b00;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (i_ack || d_ack) begin
        acks = {i_ack, d_ack};
        return;
      end
    end
  endtask

  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (mem_readM || mem_writeM) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_addr();
    logic [W-1:0] a;
    a = W'($urandom_range(0, 47));
    if ($urandom_range(0, 3) == 0) a = a | 16'hF000;
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  // Main stimulus (drives on the falling edge)
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] acks;
    bit         seen;
    bit         wr_seen;
    int         n_strobe;

    Reset_N = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    fixed_lat = 2;
    repeat (3) @(negedge Clk);
    Reset_N = 1'b1;

    // Basic I read with a 3-cycle memory.
    @(negedge Clk);
    i_addr = 16'h0013; i_req = 1'b1;
    n_strobe = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (i_ack) begin
        seen = 1'b1;
        break;
      end
      if (mem_readM && mem_address == 16'h0010) n_strobe++;
    end
    check("t1_ack_seen", 128'(seen), 128'(1));
    check("t1_strobe_cycles", 128'(n_strobe), 128'(3));
    check("t1_rdata", 128'(i_rdata), 128'(64'h1111_2222_3333_4444));
    check("t1_count", 128'(num_mem_access), 128'(1));
    i_req = 1'b0;

    // Two simultaneous pairs: D then I each time.
    fixed_lat = 1;
    for (int p = 0; p < 2; p++) begin
      repeat (2) @(negedge Clk);
      i_addr = 16'h0040; d_addr = 16'h0048; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      wait_any(acks);
      check("pair_first_d", 128'(acks), 128'(2'b01));
      if (acks[0]) d_req = 1'b0;
      if (acks[1]) i_req = 1'b0;
      wait_any(acks);
      check("pair_second_i", 128'(acks), 128'(2'b10));
      i_req = 1'b0; d_req = 1'b0;
    end

    // D write-back.
    repeat (2) @(negedge Clk);
    d_we = 1'b1; d_addr = 16'h0027; d_wdata = 64'hDEAD_BEEF_0000_FFFF; d_req = 1'b1;
    wr_seen = 1'b0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (d_ack) begin
        seen = 1'b1;
        break;
      end
      if (mem_writeM && !wr_seen) begin
        wr_seen = 1'b1;
        check("wr_port", 128'({mem_readM, mem_writeM, mem_address}),
              128'({2'b01, 16'h0024}));
        check("wr_wdata", 128'(mem_wdata), 128'(64'hDEAD_BEEF_0000_FFFF));
      end
    end
    check("wr_strobe_seen", 128'(wr_seen), 128'(1));
    check("wr_ack_seen", 128'(seen), 128'(1));
    check("wr_rdata_kept", 128'(d_rdata), 128'(line_init(16'h0048)));
    d_req = 1'b0; d_we = 1'b0;

    // Spurious mem_ready while idle, then an I read whose address moves mid-way.
    repeat (2) @(negedge Clk);
    spur_cnt++;
    repeat (3) @(negedge Clk);
    check("spur_count", 128'(num_mem_access), 128'(6));
    check("spur_no_ack", 128'({i_ack, d_ack}), 128'(0));
    fixed_lat = 3;
    i_addr = 16'h0031; i_req = 1'b1;
    wait_strobe(seen);
    check("addr_strobe_seen", 128'(seen), 128'(1));
    i_addr = 16'h007F;
    @(negedge Clk);
    check("addr_held", 128'({mem_readM, mem_address}), 128'({1'b1, 16'h0030}));
    wait_any(acks);
    check("addr_ack", 128'(acks), 128'(2'b10));
    check("addr_rdata", 128'(i_rdata), 128'(line_init(16'h0030)));
    check("addr_count", 128'(num_mem_access), 128'(7));
    i_req = 1'b0;

    // Reset pulse in the middle of a D read; the held request is re-granted.
    repeat (2) @(negedge Clk);
    d_addr = 16'h0055; d_we = 1'b0; d_req = 1'b1;
    wait_strobe(seen);
    check("rst_strobe_seen", 128'(seen), 128'(1));
    #2 Reset_N = 1'b0;
    #1 check("rst_port", 128'({mem_readM, mem_writeM, i_ack, d_ack, num_mem_access}),
             128'(0));
    @(negedge Clk);
    #2 Reset_N = 1'b1;
    wait_any(acks);
    check("rst_regrant", 128'(acks), 128'(2'b01));
    check("rst_rdata", 128'(d_rdata), 128'(line_init(16'h0054)));
    check("rst_count", 128'(num_mem_access), 128'(1));
    d_req = 1'b0;

    // Counter wrap from 0xFFFF.
    repeat (2) @(negedge Clk);
    force dut.count_q = 16'hFFFF;
    force_cnt++;
    #1 release dut.count_q;
    @(negedge Clk);
    check("wrap_preload", 128'(num_mem_access), 128'(16'hFFFF));
    fixed_lat = 0;
    i_addr = 16'h0005; i_req = 1'b1;
    wait_any(acks);
    check("wrap_ack", 128'(acks), 128'(2'b10));
    check("wrap_count", 128'(num_mem_access), 128'(0));
    i_req = 1'b0;

    // Randomized traffic.
    fixed_lat = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clk);
      if (i_req) begin
        if (i_ack) i_req = 1'b0;
        else if ($urandom_range(0, 3) == 0) i_addr = rand_addr();
      end else if ($urandom_range(0, 2) == 0) begin
        i_addr = rand_addr();
        i_req  = 1'b1;
      end
      if (d_req) begin
        if (d_ack) d_req = 1'b0;
        else if ($urandom_range(0, 3) == 0) d_wdata = {$urandom, $urandom};
      end else if ($urandom_range(0, 2) == 0) begin
        d_addr  = rand_addr();
        d_we    = ($urandom_range(0, 1) == 1);
        d_wdata = {$urandom, $urandom};
        d_req   = 1'b1;
      end
    end

    // Drain outstanding requests.
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (i_ack) i_req = 1'b0;
      if (d_ack) d_req = 1'b0;
      if (!i_req && !d_req) break;
    end
    check("drain_reqs", 128'({i_req, d_req}), 128'(0));
    repeat (4) @(negedge Clk);
    check("drain_scoreboard", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog expired");
  end

endmodule
